axi_core_master: RTL and testbench
==================================

Name: axi_core_master

Overview:
- AXI4 master bridge between a simple core-side memory port (CPU fetch/load-store unit) and the AXI bus. It is the initiator counterpart of the SRAM-side slave wrappers.
- Converts one core request at a time into a single-beat AXI read (AR/R) or write (AW/W/B) transaction.
- Returns read data, completion and an error flag to the core.
- Sits between the CPU and the AXI interconnect, one instance per master port.

Parameters:
MASTER_ID, 4'h0, value driven on ARID/AWID
ID_W, 4, AXI ID width
ADDR_W, 32, address width
DATA_W, 32, data width (STRB_W = DATA_W/8)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
core_req  in  1  request strobe; sampled only while core_busy=0
core_write  in  1  1=write, 0=read; sampled with core_req
core_addr  in  ADDR_W  byte address
core_wstrb  in  STRB_W  byte strobe, passed unchanged to WSTRB
core_wdata  in  DATA_W  write data
core_busy  out  1  transaction in flight
core_done  out  1  one-cycle completion pulse
core_rdata  out  DATA_W  read data, valid while core_done=1 and held until next read completes
core_err  out  1  response was not OKAY; valid with core_done
ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  out  ID_W/ADDR_W/4/3/2/1  read address channel
ARREADY  in  1
RID/RDATA/RRESP/RLAST/RVALID  in  ID_W/DATA_W/2/1/1
RREADY  out  1
AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  out  ID_W/ADDR_W/4/3/2/1  write address channel
AWREADY  in  1
WDATA/WSTRB/WLAST/WVALID  out  DATA_W/STRB_W/1/1
WREADY  in  1
BID/BRESP/BVALID  in  ID_W/2/1
BREADY  out  1

Behaviour:
- States: IDLE, RADDR, RDATA, WREQ, WRESP.
- Reset (async, immediate): state=IDLE; all VALID/READY outputs 0; core_busy=0, core_done=0, core_err=0, core_rdata=0; request registers 0.
- IDLE: if core_req=1, latch addr/write/wstrb/wdata. Next state is WREQ (write) or RADDR (read). core_busy=0 only in IDLE.
- Requests arriving while busy are ignored, not queued.
- Constant fields: ARLEN/AWLEN=0; ARSIZE/AWSIZE=3'b010; ARBURST/AWBURST=INCR (2'b01); WLAST=1 whenever WVALID=1; IDs=MASTER_ID. All address/data outputs come from the latched registers.
- RADDR: ARVALID=1 and held with ARADDR stable until ARREADY. On handshake go to RDATA. No combinational path from ARREADY to ARVALID.
- RDATA: RREADY=1.
  - On the first RVALID&RREADY, capture RDATA into core_rdata and OR (RRESP!=OKAY) into the error flag.
  - On RVALID&RREADY&RLAST, go to IDLE.
  - Beats before RLAST are consumed and their data is discarded; their RRESP still accumulates into the error flag.
- WREQ: AWVALID and WVALID asserted together. Independent flags aw_ok/w_ok set on each channel's handshake. A VALID drops the cycle after its own handshake and is never reasserted.
  - Both handshakes in the same cycle is legal.
  - Go to WRESP when both flags are set, counting the current cycle's handshakes.
- WRESP: BREADY=1. On BVALID, error = (BRESP!=OKAY), go to IDLE.
- core_done is registered: a 1-cycle pulse in the cycle after the final R or B handshake. core_err is valid in the same cycle. That cycle is IDLE, so a new core_req may be accepted in it.
- Minimum latency with zero-wait slave, counting from the cycle core_req is sampled:
  - read: ARVALID at +1, R handshake at +2, core_done at +3.
  - write: AW/W at +1, B at +2, core_done at +3.
- RID/BID are not checked.
- Reset mid-transaction abandons the transaction; no done pulse.

Decomposition:
- Shared package (axi_pkg): AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR, BURST_INCR, SIZE_WORD, width constants, and the state enum typedef.
- Single module, no sub-modules. The optional write-channel flag pair stays inline.

Test Plan:
1. Read addr 32'h0000_0010, slave ARREADY=1, RVALID next cycle with RDATA=32'hDEAD_BEEF, RLAST=1 -> ARADDR=32'h10, ARLEN=0, ARSIZE=2; core_done at +3; core_rdata=32'hDEADBEEF; core_err=0.
2. Read with ARREADY held low 3 cycles -> ARVALID=1 and ARADDR constant all 4 cycles; RREADY rises only after the AR handshake; one done pulse.
3. Write addr 32'h24, wdata 32'h1234_5678, wstrb 4'b0011; AWREADY at +1, WREADY at +4 -> AWVALID drops after +1; WVALID held to +4 with WLAST=1; BREADY only in WRESP; done one cycle after B.
4. Write with AW and W ready in the same cycle, then BRESP=2'b10 -> direct WREQ->WRESP; core_done=1 with core_err=1.
5. core_req pulsed while busy during read -> ignored; exactly one AR issued; core_busy=1 until done.
6. rst low mid-WREQ with WVALID high -> all VALID/READY outputs 0 immediately; no core_done; after release a new read completes normally.

Source files
------------

// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Shared AXI constants and types for the core-side AXI master bridge.
//   - AXI response codes, burst/size encodings, channel field widths
//   - state_t : bridge FSM state encoding
//   - resp_is_err() : true for any response other than OKAY
// No ports (package).
// -----------------------------------------------------------------------------
package axi_pkg;

    localparam int LEN_W   = 4;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int RESP_W  = 2;

    localparam logic [RESP_W-1:0]  AXI_RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0]  AXI_RESP_EXOKAY = 2'b01;
    localparam logic [RESP_W-1:0]  AXI_RESP_SLVERR = 2'b10;
    localparam logic [RESP_W-1:0]  AXI_RESP_DECERR = 2'b11;

    localparam logic [BURST_W-1:0] BURST_INCR = 2'b01;
    localparam logic [SIZE_W-1:0]  SIZE_WORD  = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RADDR,
        ST_RDATA,
        ST_WREQ,
        ST_WRESP
    } state_t;

    // EXOKAY is treated as an error too: this master never issues exclusive accesses.
    function automatic logic resp_is_err(input logic [RESP_W-1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_core_master_if.sv
// -----------------------------------------------------------------------------
// axi_core_master_if
// Single-beat AXI4 bus bundle (AR/R/AW/W/B channels) between the core-side
// master bridge and the interconnect.
//   modport master : drives AR/AW/W valid+payload, RREADY, BREADY
//   modport slave  : drives ARREADY, AWREADY, WREADY, R and B channels
// Parameters: ID_W, ADDR_W, DATA_W (strobe width is DATA_W/8).
// -----------------------------------------------------------------------------
interface axi_core_master_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import axi_pkg::*;

    localparam int STRB_W = DATA_W / 8;

    // read address
    logic [ID_W-1:0]    arid;
    logic [ADDR_W-1:0]  araddr;
    logic [LEN_W-1:0]   arlen;
    logic [SIZE_W-1:0]  arsize;
    logic [BURST_W-1:0] arburst;
    logic               arvalid;
    logic               arready;
    // read data
    logic [ID_W-1:0]    rid;
    logic [DATA_W-1:0]  rdata;
    logic [RESP_W-1:0]  rresp;
    logic               rlast;
    logic               rvalid;
    logic               rready;
    // write address
    logic [ID_W-1:0]    awid;
    logic [ADDR_W-1:0]  awaddr;
    logic [LEN_W-1:0]   awlen;
    logic [SIZE_W-1:0]  awsize;
    logic [BURST_W-1:0] awburst;
    logic               awvalid;
    logic               awready;
    // write data
    logic [DATA_W-1:0]  wdata;
    logic [STRB_W-1:0]  wstrb;
    logic               wlast;
    logic               wvalid;
    logic               wready;
    // write response
    logic [ID_W-1:0]    bid;
    logic [RESP_W-1:0]  bresp;
    logic               bvalid;
    logic               bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/axi_core_master.sv
// -----------------------------------------------------------------------------
// axi_core_master
// Bridges a simple one-request-at-a-time core memory port onto AXI4. Each
// accepted request becomes one single-beat AXI read (AR/R) or write (AW/W/B).
// Read data, a one-cycle completion pulse and an error flag go back to the core.
//
// Ports:
//   clk, rst      clock; asynchronous active-low reset
//   core_req      request strobe, sampled only while core_busy=0
//   core_write    1=write, 0=read (sampled with core_req)
//   core_addr     byte address
//   core_wstrb    byte strobe, forwarded unchanged to WSTRB
//   core_wdata    write data
//   core_busy     transaction in flight (low only in IDLE)
//   core_done     one-cycle pulse after the final R or B handshake
//   core_rdata    read data, held until the next read completes
//   core_err      response was not OKAY, valid with core_done
//   axi           AXI bus, master modport
// -----------------------------------------------------------------------------
module axi_core_master
    import axi_pkg::*;
#(
    parameter int            ID_W      = 4,
    parameter logic [ID_W-1:0] MASTER_ID = 4'h0,
    parameter int            ADDR_W    = 32,
    parameter int            DATA_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_req,
    input  logic                  core_write,
    input  logic [ADDR_W-1:0]     core_addr,
    input  logic [DATA_W/8-1:0]   core_wstrb,
    input  logic [DATA_W-1:0]     core_wdata,
    output logic                  core_busy,
    output logic                  core_done,
    output logic [DATA_W-1:0]     core_rdata,
    output logic                  core_err,
    axi_core_master_if.master     axi
);

    localparam int STRB_W = DATA_W / 8;

    state_t              state;

    // latched request
    logic [ADDR_W-1:0]   addr_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [DATA_W-1:0]   wdata_q;

    // registered handshake outputs
    logic                arvalid_q;
    logic                rready_q;
    logic                awvalid_q;
    logic                wvalid_q;
    logic                bready_q;

    // write channel progress and read-burst bookkeeping
    logic                aw_ok;
    logic                w_ok;
    logic                rd_first;
    logic                rd_err;

    logic                ar_hs;
    logic                r_hs;
    logic                aw_hs;
    logic                w_hs;
    logic                b_hs;
    logic                r_beat_err;

    assign ar_hs      = arvalid_q & axi.arready;
    assign r_hs       = rready_q  & axi.rvalid;
    assign aw_hs      = awvalid_q & axi.awready;
    assign w_hs       = wvalid_q  & axi.wready;
    assign b_hs       = bready_q  & axi.bvalid;
    assign r_beat_err = resp_is_err(axi.rresp);

    // Response IDs are not checked: only one transaction is ever outstanding.
    logic unused_ids;
    assign unused_ids = ^{axi.rid, axi.bid};

    assign core_busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            wstrb_q    <= '0;
            wdata_q    <= '0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            aw_ok      <= 1'b0;
            w_ok       <= 1'b0;
            rd_first   <= 1'b0;
            rd_err     <= 1'b0;
            core_done  <= 1'b0;
            core_err   <= 1'b0;
            core_rdata <= '0;
        end else begin
            core_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (core_req) begin
                        addr_q  <= core_addr;
                        wstrb_q <= core_wstrb;
                        wdata_q <= core_wdata;
                        if (core_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_ok     <= 1'b0;
                            w_ok      <= 1'b0;
                            state     <= ST_WREQ;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= ST_RADDR;
                        end
                    end
                end

                ST_RADDR: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        rd_first  <= 1'b1;
                        rd_err    <= 1'b0;
                        state     <= ST_RDATA;
                    end
                end

                ST_RDATA: begin
                    // Only the first beat's data is kept; every beat's RRESP
                    // contributes to the error flag.
                    if (r_hs) begin
                        rd_first <= 1'b0;
                        rd_err   <= rd_err | r_beat_err;
                        if (rd_first) begin
                            core_rdata <= axi.rdata;
                        end
                        if (axi.rlast) begin
                            rready_q  <= 1'b0;
                            core_done <= 1'b1;
                            core_err  <= rd_err | r_beat_err;
                            state     <= ST_IDLE;
                        end
                    end
                end

                ST_WREQ: begin
                    // AW and W complete independently; each VALID drops after
                    // its own handshake and is never raised again.
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_ok     <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_ok     <= 1'b1;
                    end
                    if ((aw_ok || aw_hs) && (w_ok || w_hs)) begin
                        bready_q <= 1'b1;
                        state    <= ST_WRESP;
                    end
                end

                ST_WRESP: begin
                    if (b_hs) begin
                        bready_q  <= 1'b0;
                        core_done <= 1'b1;
                        core_err  <= resp_is_err(axi.bresp);
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Fixed single-beat, word-sized INCR transfers; payload from latched request.
    assign axi.arid    = MASTER_ID;
    assign axi.araddr  = addr_q;
    assign axi.arlen   = '0;
    assign axi.arsize  = SIZE_WORD;
    assign axi.arburst = BURST_INCR;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

    assign axi.awid    = MASTER_ID;
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = '0;
    assign axi.awsize  = SIZE_WORD;
    assign axi.awburst = BURST_INCR;
    assign axi.awvalid = awvalid_q;

    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = wvalid_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;

endmodule

// File: tb/tb_axi_core_master.sv
// -----------------------------------------------------------------------------
// tb_axi_core_master
// Directed bench for axi_core_master. Stimulus tasks play the AXI slave cycle
// by cycle; each issued transaction pushes its expected core response into a
// queue, and a monitor pops and compares on every core_done pulse.
// -----------------------------------------------------------------------------
module tb_axi_core_master;
    import axi_pkg::*;

    localparam int            ID_W   = 4;
    localparam int            ADDR_W = 32;
    localparam int            DATA_W = 32;
    localparam int            STRB_W = DATA_W / 8;
    localparam logic [ID_W-1:0] M_ID = 4'h3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              core_req = 1'b0;
    logic              core_write = 1'b0;
    logic [ADDR_W-1:0] core_addr = '0;
    logic [STRB_W-1:0] core_wstrb = '0;
    logic [DATA_W-1:0] core_wdata = '0;
    logic              core_busy;
    logic              core_done;
    logic [DATA_W-1:0] core_rdata;
    logic              core_err;

    axi_core_master_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

    axi_core_master #(
        .ID_W      (ID_W),
        .MASTER_ID (M_ID),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_write (core_write),
        .core_addr  (core_addr),
        .core_wstrb (core_wstrb),
        .core_wdata (core_wdata),
        .core_busy  (core_busy),
        .core_done  (core_done),
        .core_rdata (core_rdata),
        .core_err   (core_err),
        .axi        (axi)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              err;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   ar_cnt   = 0;
    int   aw_cnt   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: one expected entry per completion pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst && core_done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done with empty queue, expected none");
            end else begin
                e = sb.pop_front();
                chk("sb_rdata", 64'(core_rdata), 64'(e.rdata));
                chk("sb_err", 64'(core_err), 64'(e.err));
            end
        end
    end

    // Address handshake counters.
    always @(negedge clk) begin
        if (rst && axi.arvalid && axi.arready) ar_cnt++;
        if (rst && axi.awvalid && axi.awready) aw_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int d0;
        int ar0;
        int aw0;

        axi.arready = 1'b0; axi.rid = '0; axi.rdata = '0; axi.rresp = '0;
        axi.rlast = 1'b0; axi.rvalid = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
        axi.bid = '0; axi.bresp = '0; axi.bvalid = 1'b0;

        // ---------------- reset state ----------------
        tick(); tick();
        chk("reset_ctrl", 64'({axi.arvalid, axi.rready, axi.awvalid, axi.wvalid,
                               axi.bready, core_busy, core_done, core_err}), 64'h0);
        chk("reset_rdata", 64'(core_rdata), 64'h0);
        rst = 1'b1;
        tick();

        // ---------------- test 1: basic read ----------------
        d0 = done_cnt;
        core_req = 1'b1; core_write = 1'b0; core_addr = 32'h0000_0010;
        axi.arready = 1'b1;
        sb.push_back({32'hDEAD_BEEF, 1'b0});
        tick();                                             // +1
        core_req = 1'b0;
        chk("t1_arvalid", 64'(axi.arvalid), 64'h1);
        chk("t1_ar_fields", 64'({axi.araddr, axi.arlen, axi.arsize, axi.arburst, axi.arid}),
            64'({32'h10, 4'h0, 3'b010, 2'b01, M_ID}));
        chk("t1_rready_early", 64'(axi.rready), 64'h0);
        chk("t1_busy", 64'(core_busy), 64'h1);
        tick();                                             // +2
        chk("t1_arvalid_drop", 64'(axi.arvalid), 64'h0);
        chk("t1_rready", 64'(axi.rready), 64'h1);
        axi.arready = 1'b0;
        axi.rvalid = 1'b1; axi.rdata = 32'hDEAD_BEEF; axi.rresp = AXI_RESP_OKAY;
        axi.rlast = 1'b1; axi.rid = M_ID;
        tick();                                             // +3
        axi.rvalid = 1'b0; axi.rlast = 1'b0;
        chk("t1_done_latency", 64'(core_done), 64'h1);
        chk("t1_idle_after", 64'({core_busy, axi.rready}), 64'h0);
        tick();
        chk("t1_done_count", 64'(done_cnt - d0), 64'h1);

        // ---------------- test 2: ARREADY stalled 3 cycles ----------------
        d0 = done_cnt;
        core_req = 1'b1; core_write = 1'b0; core_addr = 32'h2000_0104;
        axi.arready = 1'b0;
        sb.push_back({32'hCAFE_0001, 1'b0});
        tick();
        core_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_arvalid_held", 64'(axi.arvalid), 64'h1);
            chk("t2_araddr_stable", 64'(axi.araddr), 64'h2000_0104);
            chk("t2_rready_low", 64'(axi.rready), 64'h0);
            if (i == 3) axi.arready = 1'b1;
            tick();
        end
        chk("t2_after_ar", 64'({axi.arvalid, axi.rready}), 64'b01);
        axi.arready = 1'b0;
        axi.rvalid = 1'b1; axi.rdata = 32'hCAFE_0001; axi.rresp = AXI_RESP_OKAY; axi.rlast = 1'b1;
        tick();
        axi.rvalid = 1'b0; axi.rlast = 1'b0;
        chk("t2_done", 64'(core_done), 64'h1);
        tick(); tick(); tick();
        chk("t2_one_done", 64'(done_cnt - d0), 64'h1);

        // ---------------- test 3: write, AW early, W late ----------------
        core_req = 1'b1; core_write = 1'b1; core_addr = 32'h0000_0024;
        core_wdata = 32'h1234_5678; core_wstrb = 4'b0011;
        axi.awready = 1'b1; axi.wready = 1'b0;
        sb.push_back({32'hCAFE_0001, 1'b0});                // rdata held from last read
        tick();                                             // +1
        core_req = 1'b0; core_write = 1'b0;
        chk("t3_valids", 64'({axi.awvalid, axi.wvalid, axi.wlast, axi.bready}), 64'b1110);
        chk("t3_aw_fields", 64'({axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.awid}),
            64'({32'h24, 4'h0, 3'b010, 2'b01, M_ID}));
        chk("t3_w_payload", 64'({axi.wdata, axi.wstrb}), 64'({32'h1234_5678, 4'b0011}));
        tick();                                             // +2
        axi.awready = 1'b0;
        chk("t3_p2", 64'({axi.awvalid, axi.wvalid, axi.wlast, axi.bready}), 64'b0110);
        tick();                                             // +3
        chk("t3_p3", 64'({axi.awvalid, axi.wvalid, axi.wlast, axi.bready}), 64'b0110);
        tick();                                             // +4
        chk("t3_p4", 64'({axi.awvalid, axi.wvalid, axi.bready}), 64'b010);
        axi.wready = 1'b1;
        tick();                                             // +5
        axi.wready = 1'b0;
        chk("t3_wresp", 64'({axi.wvalid, axi.bready, core_done}), 64'b010);
        axi.bvalid = 1'b1; axi.bresp = AXI_RESP_OKAY; axi.bid = M_ID;
        tick();                                             // +6
        axi.bvalid = 1'b0;
        chk("t3_done", 64'({core_done, axi.bready}), 64'b10);
        tick();

        // ---------------- test 4: AW+W same cycle, SLVERR ----------------
        core_req = 1'b1; core_write = 1'b1; core_addr = 32'h0000_0030;
        core_wdata = 32'hA5A5_0000; core_wstrb = 4'hF;
        axi.awready = 1'b1; axi.wready = 1'b1;
        sb.push_back({32'hCAFE_0001, 1'b1});
        tick();                                             // +1
        core_req = 1'b0; core_write = 1'b0;
        chk("t4_both_valid", 64'({axi.awvalid, axi.wvalid}), 64'b11);
        tick();                                             // +2
        axi.awready = 1'b0; axi.wready = 1'b0;
        chk("t4_direct_wresp", 64'({axi.awvalid, axi.wvalid, axi.bready}), 64'b001);
        axi.bvalid = 1'b1; axi.bresp = AXI_RESP_SLVERR;
        tick();                                             // +3
        axi.bvalid = 1'b0; axi.bresp = AXI_RESP_OKAY;
        chk("t4_done_err", 64'({core_done, core_err}), 64'b11);
        tick();

        // ---------------- test 5: request while busy is ignored ----------------
        ar0 = ar_cnt; aw0 = aw_cnt; d0 = done_cnt;
        core_req = 1'b1; core_write = 1'b0; core_addr = 32'h0000_0040;
        axi.arready = 1'b0;
        sb.push_back({32'h55AA_55AA, 1'b0});
        tick();                                             // +1
        core_write = 1'b1; core_addr = 32'h0000_0080;       // core_req still high
        chk("t5_busy1", 64'({core_busy, axi.arvalid, axi.awvalid}), 64'b110);
        tick();                                             // +2
        core_req = 1'b0; core_write = 1'b0;
        chk("t5_araddr", 64'(axi.araddr), 64'h40);
        chk("t5_busy2", 64'({core_busy, axi.awvalid}), 64'b10);
        axi.arready = 1'b1;
        tick();                                             // +3
        axi.arready = 1'b0;
        chk("t5_rready", 64'({core_busy, axi.rready}), 64'b11);
        axi.rvalid = 1'b1; axi.rdata = 32'h55AA_55AA; axi.rresp = AXI_RESP_OKAY; axi.rlast = 1'b1;
        tick();                                             // +4
        axi.rvalid = 1'b0; axi.rlast = 1'b0;
        chk("t5_done", 64'({core_done, core_busy}), 64'b10);
        tick(); tick();
        chk("t5_ar_count", 64'(ar_cnt - ar0), 64'h1);
        chk("t5_aw_count", 64'(aw_cnt - aw0), 64'h0);
        chk("t5_done_count", 64'(done_cnt - d0), 64'h1);

        // ---------------- test 6: reset mid-write ----------------
        d0 = done_cnt;
        core_req = 1'b1; core_write = 1'b1; core_addr = 32'h0000_0050;
        core_wdata = 32'hFFFF_0000; core_wstrb = 4'hF;
        axi.awready = 1'b0; axi.wready = 1'b0;
        tick();                                             // +1
        core_req = 1'b0; core_write = 1'b0;
        chk("t6_wvalid_pre", 64'(axi.wvalid), 64'h1);
        tick();                                             // +2
        #1 rst = 1'b0;
        #1;
        chk("t6_async_clear", 64'({axi.arvalid, axi.rready, axi.awvalid, axi.wvalid,
                                   axi.bready, core_busy, core_done, core_err}), 64'h0);
        chk("t6_rdata_clear", 64'(core_rdata), 64'h0);
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("t6_no_done", 64'(done_cnt - d0), 64'h0);
        chk("t6_idle", 64'({core_busy, axi.awvalid, axi.wvalid}), 64'h0);
        core_req = 1'b1; core_write = 1'b0; core_addr = 32'h0000_0060;
        axi.arready = 1'b1;
        sb.push_back({32'h0BAD_F00D, 1'b0});
        tick();                                             // +1
        core_req = 1'b0;
        chk("t6_arvalid", 64'({axi.arvalid, axi.araddr}), 64'({1'b1, 32'h60}));
        tick();                                             // +2
        axi.arready = 1'b0;
        axi.rvalid = 1'b1; axi.rdata = 32'h0BAD_F00D; axi.rresp = AXI_RESP_OKAY; axi.rlast = 1'b1;
        tick();                                             // +3
        axi.rvalid = 1'b0; axi.rlast = 1'b0;
        chk("t6_done", 64'(core_done), 64'h1);
        tick(); tick();

        chk("sb_drained", 64'(sb.size()), 64'h0);
        chk("done_total", 64'(done_cnt), 64'h6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
